spi_slave_axis: RTL and testbench
=================================

# spi_slave_axis

Synthesizable SPI slave endpoint, directly downstream of `spi_master_axi` on its `spi_sclk`/`spi_mosi`/`spi_cs_n` wires and driving `spi_miso` back to it. It oversamples the SPI pins on the system clock and presents each received word on a valid/ready stream. It takes each transmit word from a second valid/ready stream. It replaces the MOSI→MISO wire loopback in system benches and serves as the on-chip slave for chip-to-chip bring-up.

## Interface
- `WORD_WIDTH`, 32, bits per SPI word (2..32), MSB first.
- `aclk`  in  1  system clock.
- `aresetn`  in  1  synchronous, active-low reset.
- `cpol`  in  1  clock polarity; sampled when CS asserts.
- `cpha`  in  1  clock phase; sampled when CS asserts.
- `spi_sclk`  in  1  asynchronous SPI clock.
- `spi_mosi`  in  1  asynchronous master-out data.
- `spi_cs_n`  in  1  asynchronous chip select, active low.
- `spi_miso`  out  1  slave-out data.
- `tx_data`  in  WORD_WIDTH  next word to shift out.
- `tx_valid`  in  1  tx_data valid.
- `tx_ready`  out  1  one-cycle pulse: tx_data consumed.
- `rx_data`  out  WORD_WIDTH  received word.
- `rx_valid`  out  1  rx_data valid; held until accepted.
- `rx_ready`  in  1  consumer accepts rx_data.
- `rx_overrun`  out  1  one-cycle pulse: a word was dropped.
- `tx_underrun`  out  1  one-cycle pulse: no tx word was available at load.
- `busy`  out  1  CS is active (synchronized view).

## Operation
- SCLK, MOSI and CS_N each pass through a 2-flop synchronizer. A third flop on SCLK and on CS_N gives rise/fall edge detection.
- The FSM has two states, IDLE and ACTIVE.
- IDLE → ACTIVE on the synchronized CS_N falling edge. On that cycle:
  - latch `cpol`/`cpha`;
  - clear the bit counter;
  - perform a TX load.
- ACTIVE → IDLE on the synchronized CS_N rising edge, from any bit position.
  - A partial word is discarded: no rx_valid, no overrun.
  - MISO returns to 0.
- The leading edge is rising when cpol=0, falling when cpol=1.
  - cpha=0: sample on the leading edge, shift on the trailing edge.
  - cpha=1: shift on the leading edge, sample on the trailing edge. The first leading edge of a word does not shift.
- Sample edge: shift the synchronized MOSI into rx_shift[0] and increment the bit counter. At count WORD_WIDTH:
  - the word completes and the counter wraps to 0;
  - if rx_valid=0, load rx_data and set rx_valid;
  - if rx_valid=1, drop the word, pulse rx_overrun, and leave rx_data unchanged.
- Shift edge: shift tx_shift left.
- TX load happens at CS assertion and on the cycle after each word completes.
  - If tx_valid=1: tx_shift ← tx_data and pulse tx_ready.
  - Otherwise: tx_shift ← 0 and pulse tx_underrun.
- spi_miso = tx_shift[WORD_WIDTH-1] in ACTIVE; 0 in IDLE.
- rx_valid clears on the cycle rx_valid & rx_ready is high. Word completion on that same cycle is not an overrun: the new word is loaded and rx_valid stays 1.

## Timing
- The reset values of all outputs are 0: spi_miso, tx_ready, rx_data, rx_valid, rx_overrun, tx_underrun, busy.
- Reset is honored mid-transfer: the FSM goes to IDLE and the counter clears. The next word starts only after CS_N is seen high, then low.
- Pin-to-edge-detect latency is 3 aclk cycles.
- SCLK high and low phases must each be ≥ 4 aclk cycles, so the master divider must be ≥ 8 when it shares aclk.
- In cpha=0, CS_N fall to first SCLK edge must be ≥ 4 aclk cycles, so MISO is valid before the master samples.
- MISO updates 1 cycle after the detected shift edge.
- rx_valid rises 1 cycle after the final sample edge.
- tx_ready and tx_underrun are single-cycle pulses. tx_ready coincides with the load.

## Structure
- `spi_pkg` holds:
  - the `spi_mode_t` typedef {cpol, cpha};
  - the `SPI_SYNC_STAGES`=2 constant;
  - the FSM state enum `spi_slv_state_e` {IDLE, ACTIVE}.
- One sub-module, `spi_sync_2ff`: a parameterized-width 2-flop synchronizer, instantiated for {sclk, mosi, cs_n}.

## Test plan
- Mode 0: tx_data=0x12345678 preloaded; master sends 0xCAFEBABE → rx_data=0xCAFEBABE with one rx_valid, master reads 0x12345678, one tx_ready pulse.
- Mode 3: the same two words → identical results; mode 1 and mode 2 also pass.
- Two back-to-back words with rx_ready=0 → first word 0xCAFEBABE held, second 0xDEADBEEF dropped, rx_overrun pulses once.
- tx_valid=0 during a transfer → master reads 0x00000000, tx_underrun pulses once.
- CS_N released after 13 bits, then a full 0xA5A5A5A5 word → only 0xA5A5A5A5 delivered, bit alignment correct.
- aresetn low for 2 cycles mid-word → all outputs 0; the next full CS frame transfers 0x0F0F0F0F correctly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave endpoint.
package spi_pkg;

    // Depth of the pin synchronizers (metastability flops before use).
    localparam int SPI_SYNC_STAGES = 2;

    // SPI mode captured at chip-select assertion.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Slave FSM states.
    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_e;

endpackage

// File: rtl/spi_sync_2ff.sv
// Multi-bit flop-chain synchronizer for independent asynchronous inputs.
module spi_sync_2ff
    import spi_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int STAGES = SPI_SYNC_STAGES
)
(
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] stage_p;

    // Shift the asynchronous inputs through the synchronizer chain
    always_ff @(posedge clk) begin
        stage_p[0] <= d;
        for (int i = 1; i < STAGES; i++) begin
            stage_p[i] <= stage_p[i-1];
        end
    end

    assign q = stage_p[STAGES-1];

endmodule

// File: rtl/spi_slave_axis.sv
// SPI slave endpoint: oversampled SPI pins in, valid/ready word streams out/in.
module spi_slave_axis
    import spi_pkg::*;
#(
    parameter int WORD_WIDTH = 32
)
(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  spi_sclk,
    input  logic                  spi_mosi,
    input  logic                  spi_cs_n,
    output logic                  spi_miso,
    input  logic [WORD_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [WORD_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  rx_overrun,
    output logic                  tx_underrun,
    output logic                  busy
);

    localparam int              CNT_W    = (WORD_WIDTH > 2) ? $clog2(WORD_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);

    // Synchronized pins. The synchronizer is not reset: it keeps tracking the
    // pins through reset so that a CS held low across reset is not mistaken
    // for a fresh assertion afterwards.
    logic sclk_s, mosi_s, cs_n_s;

    spi_sync_2ff #(.WIDTH(3)) u_sync (
        .clk (aclk),
        .d   ({spi_sclk, spi_mosi, spi_cs_n}),
        .q   ({sclk_s, mosi_s, cs_n_s})
    );

    logic sclk_d, cs_n_d;

    // Delay flop on SCLK and CS_N for edge detection
    always_ff @(posedge aclk) begin
        sclk_d <= sclk_s;
        cs_n_d <= cs_n_s;
    end

    logic sclk_rise, sclk_fall, cs_fall, cs_rise;
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_n_s & cs_n_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;

    spi_slv_state_e   state, state_nxt;
    spi_mode_t        mode_q;
    logic [CNT_W-1:0] bit_cnt;
    logic             skip_shift;
    logic             load_pend;
    logic             load;

    logic [WORD_WIDTH-1:0] tx_shift;
    logic [WORD_WIDTH-2:0] rx_shift;
    logic [WORD_WIDTH-1:0] rx_word;

    // Edge classification under the latched mode. CS release wins over any
    // SCLK edge detected in the same cycle.
    logic lead_edge, trail_edge, edges_live;
    logic sample_edge, shift_raw, shift_edge, word_done;

    assign lead_edge   = mode_q.cpol ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_q.cpol ? sclk_rise : sclk_fall;
    assign edges_live  = (state == ACTIVE) && !cs_rise;
    assign sample_edge = edges_live && (mode_q.cpha ? trail_edge : lead_edge);
    assign shift_raw   = edges_live && (mode_q.cpha ? lead_edge : trail_edge);
    assign shift_edge  = shift_raw && !skip_shift;
    assign word_done   = sample_edge && (bit_cnt == LAST_BIT);
    assign rx_word     = {rx_shift, mosi_s};

    // FSM state register
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (cs_fall) state_nxt = ACTIVE;
            ACTIVE:  if (cs_rise) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs: pin drive, busy flag and TX load handshake
    always_comb begin
        busy        = 1'b0;
        spi_miso    = 1'b0;
        load        = 1'b0;
        tx_ready    = 1'b0;
        tx_underrun = 1'b0;
        if (state == ACTIVE) begin
            busy     = 1'b1;
            spi_miso = tx_shift[WORD_WIDTH-1];
            load     = load_pend;
        end else begin
            load     = cs_fall;
        end
        load        = load && aresetn;
        tx_ready    = load && tx_valid;
        tx_underrun = load && !tx_valid;
    end

    // Control: mode latch, bit counter, pending reload and shift suppression.
    // After a TX load the very next shift edge would push out the MSB before
    // the master has sampled it (the trailing edge of the last bit in cpha=0,
    // the first leading edge in cpha=1), so that one edge is swallowed. At CS
    // assertion in cpha=0 the first shift edge follows a real sample and must
    // shift, hence the flag starts at cpha.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mode_q     <= '0;
            bit_cnt    <= '0;
            skip_shift <= 1'b0;
            load_pend  <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            if (state == IDLE) begin
                if (cs_fall) begin
                    mode_q.cpol <= cpol;
                    mode_q.cpha <= cpha;
                    bit_cnt     <= '0;
                    skip_shift  <= cpha;
                end
            end else begin
                if (word_done) begin
                    bit_cnt    <= '0;
                    load_pend  <= 1'b1;
                    skip_shift <= 1'b1;
                end else if (sample_edge) begin
                    bit_cnt <= bit_cnt + CNT_W'(1);
                end
                if (shift_raw) begin
                    skip_shift <= 1'b0;
                end
            end
        end
    end

    // TX shift register: load a new word or shift out MSB first
    always_ff @(posedge aclk) begin
        if (load) begin
            tx_shift <= tx_valid ? tx_data : '0;
        end else if (shift_edge) begin
            tx_shift <= {tx_shift[WORD_WIDTH-2:0], 1'b0};
        end
    end

    // RX shift register: collect MOSI on every sample edge
    always_ff @(posedge aclk) begin
        if (sample_edge) begin
            rx_shift <= rx_word[WORD_WIDTH-2:0];
        end
    end

    // RX output stage: deliver completed words, flag drops, honour handshake
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (word_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_axis.sv
// Directed bench for spi_slave_axis with a word-level SPI master and stream model.
module tb_spi_slave_axis;

    localparam int H = 6;   // SCLK half period in aclk cycles

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cpol, cpha;
    logic        spi_sclk, spi_mosi, spi_cs_n;
    logic        spi_miso;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        rx_overrun, tx_underrun, busy;

    always #5 aclk = ~aclk;

    spi_slave_axis #(.WORD_WIDTH(32)) dut (
        .aclk        (aclk),
        .aresetn     (aresetn),
        .cpol        (cpol),
        .cpha        (cpha),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .tx_underrun (tx_underrun),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;

    // Observed pulse counts
    int cnt_ready = 0;
    int cnt_under = 0;
    int cnt_over  = 0;

    // Behavioural model state
    logic [31:0] src_q[$];      // words presented to the DUT tx stream
    logic [31:0] mdl_q[$];      // model's view of the same tx words
    bit          m_rx_full   = 1'b0;
    logic [31:0] m_rx_data   = 32'h0;
    int          m_ready_exp = 0;
    int          m_under_exp = 0;
    int          m_over_exp  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            if (failures <= 40)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        src_q.push_back(w);
        mdl_q.push_back(w);
    endtask

    // A TX load takes the head word if one exists, otherwise sends zeros.
    function automatic logic [31:0] mdl_load();
        if (mdl_q.size() > 0) begin
            m_ready_exp++;
            return mdl_q.pop_front();
        end
        m_under_exp++;
        return 32'h0;
    endfunction

    // A completed word is delivered if the output is free, otherwise dropped.
    function automatic void model_word(input logic [31:0] w);
        if (!m_rx_full) begin
            m_rx_full = 1'b1;
            m_rx_data = w;
        end else begin
            m_over_exp++;
        end
    endfunction

    task automatic rx_accept();
        @(negedge aclk);
        rx_ready = 1'b1;
        @(posedge aclk);
        m_rx_full = 1'b0;
        #1;
        rx_ready = 1'b0;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_tx_ready_cnt"}, cnt_ready, m_ready_exp);
        check({tag, "_underrun_cnt"}, cnt_under, m_under_exp);
        check({tag, "_overrun_cnt"}, cnt_over, m_over_exp);
        check({tag, "_rx_valid"}, rx_valid, m_rx_full);
        if (m_rx_full) check({tag, "_rx_data"}, rx_data, m_rx_data);
    endtask

    // SPI master: drives nbits of mosi_w (MSB first), reads MISO, and
    // checks each completed MISO word against the model's loaded word.
    task automatic spi_xfer(input bit cp, input bit ch, input int nbits,
                            input logic [63:0] mosi_w, input bit keep_cs,
                            output logic [31:0] last_miso);
        logic [31:0] exp_tx, miso_acc, mosi_acc;
        cpol     = cp;
        cpha     = ch;
        spi_sclk = cp;
        spi_mosi = 1'b0;
        wait_cyc(6);
        spi_cs_n = 1'b0;
        exp_tx   = mdl_load();
        wait_cyc(8);
        check("busy_active", busy, 1'b1);
        miso_acc  = '0;
        mosi_acc  = '0;
        last_miso = '0;
        for (int i = 0; i < nbits; i++) begin
            if (ch) spi_sclk = ~cp;
            spi_mosi = mosi_w[63-i];
            wait_cyc(H);
            spi_sclk = ch ? cp : ~cp;
            miso_acc = {miso_acc[30:0], spi_miso};
            mosi_acc = {mosi_acc[30:0], spi_mosi};
            if ((i % 32) == 31) begin
                check("miso_word", miso_acc, exp_tx);
                last_miso = miso_acc;
                model_word(mosi_acc);
                exp_tx = mdl_load();
            end
            wait_cyc(H);
            if (!ch) spi_sclk = cp;
        end
        wait_cyc(H);
        if (!keep_cs) begin
            spi_cs_n = 1'b1;
            wait_cyc(10);
            check("busy_idle", busy, 1'b0);
            check("miso_idle", spi_miso, 1'b0);
        end
    endtask

    // TX stream source: presents the head of src_q, pops on a handshake
    initial begin
        bit take;
        tx_valid = 1'b0;
        tx_data  = 32'hBAD0BAD0;
        forever begin
            @(negedge aclk);
            take = tx_ready && tx_valid;
            @(posedge aclk);
            #1;
            if (take && src_q.size() > 0) void'(src_q.pop_front());
            tx_valid = (src_q.size() > 0);
            tx_data  = tx_valid ? src_q[0] : 32'hBAD0BAD0;
        end
    end

    // Per-cycle compare: count pulses, and any valid RX word must be the model's
    initial begin
        forever begin
            @(negedge aclk);
            if (tx_ready)    cnt_ready++;
            if (tx_underrun) cnt_under++;
            if (rx_overrun)  cnt_over++;
            if (aresetn && rx_valid) begin
                check("rx_hold_valid", m_rx_full, 1'b1);
                check("rx_hold_data", rx_data, m_rx_data);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] miso;
        int          r0, u0, o0;
        int          modes[4] = '{0, 3, 1, 2};
        bit          cp, ch;

        aresetn  = 1'b0;
        cpol     = 1'b0;
        cpha     = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        rx_ready = 1'b0;
        wait_cyc(5);
        check("rst_miso", spi_miso, 1'b0);
        check("rst_tx_ready", tx_ready, 1'b0);
        check("rst_rx_data", rx_data, 32'h0);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_rx_overrun", rx_overrun, 1'b0);
        check("rst_tx_underrun", tx_underrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        aresetn = 1'b1;
        wait_cyc(4);

        // Single word in each SPI mode
        for (int k = 0; k < 4; k++) begin
            cp = modes[k][1];
            ch = modes[k][0];
            r0 = cnt_ready;
            u0 = cnt_under;
            push(32'h12345678);
            wait_cyc(4);
            spi_xfer(cp, ch, 32, {32'hCAFEBABE, 32'h0}, 1'b0, miso);
            check("mode_rx_data", rx_data, 32'hCAFEBABE);
            check("mode_rx_valid", rx_valid, 1'b1);
            check("mode_miso", miso, 32'h12345678);
            check("mode_tx_ready_pulses", cnt_ready - r0, 1);
            check("mode_tail_underrun", cnt_under - u0, 1);
            check_model("mode");
            rx_accept();
            wait_cyc(2);
            check("mode_rx_cleared", rx_valid, 1'b0);
        end

        // Back-to-back words with the consumer stalled
        r0 = cnt_ready;
        u0 = cnt_under;
        o0 = cnt_over;
        push(32'h11111111);
        push(32'h22222222);
        wait_cyc(4);
        spi_xfer(1'b0, 1'b0, 64, {32'hCAFEBABE, 32'hDEADBEEF}, 1'b0, miso);
        check("ovr_rx_data", rx_data, 32'hCAFEBABE);
        check("ovr_pulses", cnt_over - o0, 1);
        check("ovr_second_miso", miso, 32'h22222222);
        check("ovr_tx_ready_pulses", cnt_ready - r0, 2);
        check("ovr_underrun_pulses", cnt_under - u0, 1);
        check_model("ovr");
        rx_accept();

        // No TX word at CS assertion; one arrives mid-word for the reload
        r0 = cnt_ready;
        u0 = cnt_under;
        fork
            spi_xfer(1'b0, 1'b0, 32, {32'h5A5A5A5A, 32'h0}, 1'b0, miso);
            begin
                wait_cyc(100);
                push(32'h77777777);
            end
        join
        check("udr_miso", miso, 32'h0);
        check("udr_underrun_pulses", cnt_under - u0, 1);
        check("udr_tx_ready_pulses", cnt_ready - r0, 1);
        check("udr_rx_data", rx_data, 32'h5A5A5A5A);
        check_model("udr");
        rx_accept();

        // Aborted 13-bit frame followed by a full word
        o0 = cnt_over;
        spi_xfer(1'b0, 1'b0, 13, {32'hFFF8_0000, 32'h0}, 1'b0, miso);
        check("part_no_valid", rx_valid, 1'b0);
        spi_xfer(1'b0, 1'b0, 32, {32'hA5A5A5A5, 32'h0}, 1'b0, miso);
        check("part_rx_data", rx_data, 32'hA5A5A5A5);
        check("part_no_overrun", cnt_over - o0, 0);
        check_model("part");
        rx_accept();

        // Reset in the middle of a word, CS still low
        spi_xfer(1'b0, 1'b1, 10, {32'hFFFFFFFF, 32'h0}, 1'b1, miso);
        aresetn = 1'b0;
        wait_cyc(2);
        m_rx_full = 1'b0;
        m_rx_data = 32'h0;
        check("mid_rst_miso", spi_miso, 1'b0);
        check("mid_rst_tx_ready", tx_ready, 1'b0);
        check("mid_rst_rx_data", rx_data, 32'h0);
        check("mid_rst_rx_valid", rx_valid, 1'b0);
        check("mid_rst_rx_overrun", rx_overrun, 1'b0);
        check("mid_rst_tx_underrun", tx_underrun, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        aresetn = 1'b1;
        wait_cyc(6);
        check("post_rst_idle_cs_low", busy, 1'b0);
        spi_cs_n = 1'b1;
        wait_cyc(4);
        spi_xfer(1'b0, 1'b1, 32, {32'h0F0F0F0F, 32'h0}, 1'b0, miso);
        check("post_rst_rx_data", rx_data, 32'h0F0F0F0F);
        check_model("post_rst");
        rx_accept();

        wait_cyc(5);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
